// File: rtl/nios2_mul_pkg.sv
// Shared types and helpers for the Nios II pipelined multiplier.
package nios2_mul_pkg;

   typedef enum logic [1:0] {
      MUL_LO  = 2'b00,
      MULX_UU = 2'b01,
      MULX_SU = 2'b10,
      MULX_SS = 2'b11
   } mul_mode_e;

   localparam int WIDTH_DEF = 32;
   localparam int SLICE_DEF = 16;
   localparam int N         = WIDTH_DEF / SLICE_DEF;

   function automatic logic is_signed_a(mul_mode_e mode);
      return (mode == MULX_SU) || (mode == MULX_SS);
   endfunction

   function automatic logic is_signed_b(mul_mode_e mode);
      return mode == MULX_SS;
   endfunction

endpackage

// File: rtl/nios2_mul_pp_array.sv
// Registered array of unsigned SLICE x SLICE partial products,
// one product per DSP block.
module nios2_mul_pp_array #(
   parameter int WIDTH = 32,
   parameter int SLICE = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic [WIDTH-1:0]               a,
   input  logic [WIDTH-1:0]               b,
   output logic [2*WIDTH*WIDTH/SLICE-1:0] pp
);

   localparam int NSL = WIDTH / SLICE;
   localparam int PW  = 2 * SLICE;

   for (genvar i = 0; i < NSL; i++) begin : g_a
      for (genvar j = 0; j < NSL; j++) begin : g_b
         logic [PW-1:0] xa;
         logic [PW-1:0] xb;
         logic [PW-1:0] q;

         assign xa = {{SLICE{1'b0}}, a[i*SLICE +: SLICE]};
         assign xb = {{SLICE{1'b0}}, b[j*SLICE +: SLICE]};

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               q <= '0;
            end else if (en) begin
               q <= xa * xb;
            end
         end

         assign pp[(i*NSL+j)*PW +: PW] = q;
      end
   end

endmodule

// File: rtl/nios2_mul_pipe.sv
// Two-stage WIDTH x WIDTH multiplier between E and M with
// valid/ready handshake, flush, and low/high word select.
module nios2_mul_pipe
   import nios2_mul_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result
);

   localparam int NSL = WIDTH / SLICE;
   localparam int PW  = 2 * SLICE;
   localparam int W2  = 2 * WIDTH;

   mul_mode_e                 mode_in;
   mul_mode_e                 s1_mode;
   logic                      s1_valid;
   logic                      s1_adv;
   logic                      s2_adv;
   logic                      accept;
   logic [WIDTH-1:0]          corr_a;
   logic [WIDTH-1:0]          corr_b;
   logic [WIDTH-1:0]          s1_corr_a;
   logic [WIDTH-1:0]          s1_corr_b;
   logic [NSL*NSL*PW-1:0]     s1_pp;
   logic [W2-1:0]             prod;
   logic [WIDTH-1:0]          res_sel;

   assign mode_in  = mul_mode_e'(in_mode);
   assign s2_adv   = ~out_valid | out_ready;
   assign s1_adv   = ~s1_valid | s2_adv;
   assign in_ready = s1_adv & ~flush;
   assign accept   = in_valid & in_ready;

   // Sign handled by subtracting the MSB-weighted other operand
   assign corr_a = (is_signed_a(mode_in) && in_a[WIDTH-1]) ? in_b : '0;
   assign corr_b = (is_signed_b(mode_in) && in_b[WIDTH-1]) ? in_a : '0;

   nios2_mul_pp_array #(
      .WIDTH (WIDTH),
      .SLICE (SLICE)
   ) u_pp (
      .clk   (clk),
      .reset (reset),
      .en    (accept),
      .a     (in_a),
      .b     (in_b),
      .pp    (s1_pp)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else if (flush) begin
         s1_valid  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         if (s1_adv) s1_valid  <= accept;
         if (s2_adv) out_valid <= s1_valid;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_mode    <= MUL_LO;
         s1_corr_a  <= '0;
         s1_corr_b  <= '0;
         out_result <= '0;
      end else begin
         if (accept) begin
            s1_mode   <= mode_in;
            s1_corr_a <= corr_a;
            s1_corr_b <= corr_b;
         end
         if (s2_adv && s1_valid && !flush) begin
            out_result <= res_sel;
         end
      end
   end

   always_comb begin
      logic [W2-1:0] term;
      prod = '0;
      for (int i = 0; i < NSL; i++) begin
         for (int j = 0; j < NSL; j++) begin
            term = '0;
            term[PW-1:0] = s1_pp[(i*NSL+j)*PW +: PW];
            prod = prod + (term << (SLICE * (i + j)));
         end
      end
      term = '0;
      term[W2-1:WIDTH] = s1_corr_a;
      prod = prod - term;
      term = '0;
      term[W2-1:WIDTH] = s1_corr_b;
      prod = prod - term;
   end

   assign res_sel = (s1_mode == MUL_LO) ? prod[WIDTH-1:0]
                                        : prod[W2-1:WIDTH];

endmodule
